// File: rtl/wb_ram_bridge.sv
// rtl/wb_ram_bridge.sv - Wishbone slave bridge into the uP16 program/data RAM banks
// Halts the CPU via hold/ack, then performs a word read, word write or byte read-modify-write.
module wb_ram_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_C000,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cpu_hold_o,
    input  logic        cpu_hold_ack_i,
    output logic        mem_own_o,
    output logic [11:0] mem_addr_o,
    output logic [15:0] mem_data_o,
    output logic        mem_en_o,
    output logic        mem_rw_o,
    input  logic [15:0] mem_data_i,
    output logic        bridge_err_o
);

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RD, S_WR, S_ACK} state_t;

    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);
    localparam logic [1:0] LAT_MAX = 2'(RD_LAT);

    state_t      state_q;
    logic [7:0]  tmo_cnt_q;
    logic [1:0]  lat_cnt_q;
    logic        we_q;
    logic [1:0]  sel_q;
    logic [15:0] wdata_q;
    logic        abort_q;
    logic [15:0] merged_d;
    logic        hit;
    logic        unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};
    assign hit = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR) & ~wbs_ack_o;

    // Selected byte lanes come from the write data, the rest from the word just read.
    always_comb begin
        merged_d = mem_data_i;
        if (sel_q[0]) merged_d[7:0]  = wdata_q[7:0];
        if (sel_q[1]) merged_d[15:8] = wdata_q[15:8];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= S_IDLE;
            tmo_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            wdata_q      <= '0;
            abort_q      <= 1'b0;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            cpu_hold_o   <= 1'b0;
            mem_own_o    <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_en_o     <= 1'b0;
            mem_rw_o     <= 1'b0;
            bridge_err_o <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        mem_addr_o <= wbs_adr_i[13:2];
                        wdata_q    <= wbs_dat_i[15:0];
                        we_q       <= wbs_we_i;
                        sel_q      <= wbs_sel_i[1:0];
                        tmo_cnt_q  <= '0;
                        abort_q    <= 1'b0;
                        cpu_hold_o <= 1'b1;
                        state_q    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!wbs_cyc_i) begin
                        cpu_hold_o <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (cpu_hold_ack_i) begin
                        if (!we_q || (sel_q[0] ^ sel_q[1])) begin
                            mem_own_o <= 1'b1;
                            mem_en_o  <= 1'b1;
                            mem_rw_o  <= 1'b0;
                            lat_cnt_q <= '0;
                            state_q   <= S_RD;
                        end else if (sel_q == 2'b11) begin
                            mem_own_o  <= 1'b1;
                            mem_en_o   <= 1'b1;
                            mem_rw_o   <= 1'b1;
                            mem_data_o <= wdata_q;
                            state_q    <= S_WR;
                        end else begin
                            wbs_ack_o <= 1'b1;
                            state_q   <= S_ACK;
                        end
                    end else if (tmo_cnt_q == TMO_MAX) begin
                        wbs_ack_o    <= 1'b1;
                        wbs_dat_o    <= 32'hDEAD_BEEF;
                        bridge_err_o <= 1'b1;
                        state_q      <= S_ACK;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                S_RD: begin
                    if (!wbs_cyc_i) abort_q <= 1'b1;
                    if (lat_cnt_q == LAT_MAX) begin
                        if (we_q) begin
                            mem_rw_o   <= 1'b1;
                            mem_data_o <= merged_d;
                            state_q    <= S_WR;
                        end else if (abort_q || !wbs_cyc_i) begin
                            mem_en_o   <= 1'b0;
                            mem_own_o  <= 1'b0;
                            cpu_hold_o <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            mem_en_o  <= 1'b0;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= {16'h0, mem_data_i};
                            state_q   <= S_ACK;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 2'd1;
                    end
                end
                S_WR: begin
                    mem_en_o <= 1'b0;
                    mem_rw_o <= 1'b0;
                    if (abort_q || !wbs_cyc_i) begin
                        mem_own_o  <= 1'b0;
                        cpu_hold_o <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        wbs_ack_o <= 1'b1;
                        state_q   <= S_ACK;
                    end
                end
                S_ACK: begin
                    cpu_hold_o <= 1'b0;
                    mem_own_o  <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_ram_bridge.md
# wb_ram_bridge

Wishbone-slave bridge that gives the management SoC word access to the four 1K×16 program/data RAM banks of the uP16 core. It sits directly upstream of the SoC configuration/glue stage. It drives that stage's memory-override path (12-bit word address, 16-bit data, enable, read/write) and receives the muxed bank read data back. Before touching memory it halts the CPU through a request/acknowledge handshake, and it supports byte-lane writes by read-modify-write.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000: Wishbone window base.
- ADDR_MASK, 32'hFFFF_C000: window mask (16 KB; one 16-bit RAM word per 32-bit WB word).
- RD_LAT, 1: RAM read latency in cycles (1..3).
- TIMEOUT, 255: max cycles to wait for CPU hold acknowledge (8-bit counter).

Ports:
- wb_clk_i  in  1  the single clock, shared by Wishbone and the RAMs.
- wb_rst_ni  in  1  reset, asynchronous and active-low.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write.
- wbs_sel_i  in  4  byte selects; only [1:0] are used.
- wbs_dat_i  in  32  write data; [15:0] used.
- wbs_adr_i  in  32  byte address; word index = adr[13:2].
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, {16'h0, word}.
- cpu_hold_o  out  1  request for the CPU to stall and release its memory bus.
- cpu_hold_ack_i  in  1  CPU is stalled.
- mem_own_o  out  1  selects the bridge as the memory master in the glue stage.
- mem_addr_o  out  12  bank[11:10] and word[9:0].
- mem_data_o  out  16  write data.
- mem_en_o  out  1  active-high enable (the glue stage converts it to active-low chip selects).
- mem_rw_o  out  1  1 = write (the glue stage inverts it for OpenRAM).
- mem_data_i  in  16  muxed bank read data.
- bridge_err_o  out  1  sticky flag for a hold timeout.

## Operation
- Hit condition: cyc & stb & ((adr & ADDR_MASK) == BASE_ADDR) & ~wbs_ack_o. Out-of-window requests are ignored and never acknowledged.
- The FSM has five states: IDLE, HOLD, RD, WR, ACK. All outputs are registered.
- IDLE:
  - On a hit, latch adr[13:2], dat_i[15:0], we and sel[1:0].
  - Set cpu_hold_o = 1 and go to HOLD.
  - Clear the timeout counter.
- HOLD: wait for cpu_hold_ack_i.
  - When cpu_hold_ack_i is seen:
    - Read goes to RD.
    - Write with sel[1:0] = 11 goes to WR.
    - Write with sel[1:0] = 01 or 10 goes to RD (read-modify-write).
    - Write with sel[1:0] = 00 goes to ACK with no memory access.
  - If the counter reaches TIMEOUT first: go to ACK with dat_o = 32'hDEAD_BEEF, perform no memory access, set bridge_err_o.
- RD:
  - mem_own_o = 1, mem_en_o = 1, mem_rw_o = 0 for RD_LAT+1 cycles.
  - On the last cycle, capture mem_data_i.
  - Read goes to ACK with dat_o = {16'h0, captured}.
  - RMW merges the captured word with the new data: sel[0] takes byte [7:0] from write data, sel[1] takes byte [15:8] from write data. Then go to WR.
- WR: mem_own_o = 1, mem_en_o = 1, mem_rw_o = 1 for exactly one cycle, then ACK.
- ACK:
  - wbs_ack_o = 1 for one cycle; mem_en_o = 0; mem_own_o is still 1.
  - Next state is IDLE, where cpu_hold_o and mem_own_o drop.
- Each transaction re-handshakes the hold. The bridge never holds the CPU between transactions.
- Master abort (cyc low before ACK):
  - In HOLD: return to IDLE with no memory access.
  - In RD/WR: finish the memory sequence, suppress the ack, return to IDLE.
- bridge_err_o is cleared only by reset.

## Timing
- Reset (async assert, sync release): state = IDLE. All outputs are 0: ack, dat_o, cpu_hold_o, mem_own_o, mem_en_o, mem_rw_o, mem_addr_o, mem_data_o, bridge_err_o.
- Reset mid-transaction: the CPU is released immediately and the pending WB cycle is never acknowledged.
- Cycle numbering: T0 is the edge that samples the hit. Assume cpu_hold_ack_i is already high at T1.
  - Full-word write: HOLD at T1, WR at T2, ack at T3.
  - Read (RD_LAT = 1): RD at T2–T3, ack at T4.
  - Byte write (RD_LAT = 1): RD at T2–T3, WR at T4, ack at T5.
- Each cycle cpu_hold_ack_i arrives late adds one cycle.
- Timeout: ack arrives TIMEOUT+2 cycles after T0.
- mem_addr_o and mem_data_o are stable for the whole time mem_en_o is high.
- wbs_dat_o is valid only while ack = 1, and 0 otherwise.

## Test plan
- Full write then read:
  - Write 0x3000_0804 = 0x1234 with sel = F.
  - Required: one WR cycle with mem_addr_o = 0x201, mem_data_o = 0x1234, rw = 1, ack at T3.
  - Reading the same address returns 0x0000_1234, ack at T4.
- Byte RMW:
  - Memory word 0x201 holds 0xABCD. Write 0x0000_0055 with sel = 1.
  - Required: RD then WR of 0xAB55, ack at T5.
  - Repeat with sel = 2 and data 0x9900; required WR value is 0x99CD.
- Hold handshake delay: raise cpu_hold_ack_i 5 cycles after cpu_hold_o. Required: mem_en_o stays 0 until then, and ack is delayed by 4 cycles relative to the no-wait case.
- Timeout:
  - Keep cpu_hold_ack_i = 0 with TIMEOUT = 8.
  - Required: ack with 0xDEAD_BEEF at T10, bridge_err_o = 1 and stays set, mem_en_o never asserted.
- Out-of-window: access 0x3000_4000. Required: no hold request, no ack.
- Abort and reset:
  - Drop cyc in HOLD. Required: return to IDLE, no mem_en_o, no ack.
  - Assert wb_rst_ni = 0 during RD. Required: all outputs 0 asynchronously.
  - A transaction after reset completes normally.
